vernam_deciph: RTL and testbench
================================

// Module: vernam_deciph
// PURPOSE
//  Receive-side Vernam stream decipher. Recovers 8-bit plaintext by XOR with a
//  keystream that is bit-identical to the encipher side's keystream.
//  Sits after the link/channel, upstream of the character sink.
//  Valid/ready on both sides, one-entry output register, byte counter, resync.
// PARAMETERS
//  KEY_SEED    8'hA5  LFSR load value at reset/resync; must equal encipher seed
//  BYTE_CNT_W  16     width of the deciphered-byte counter
// PORTS
//  clk       in   1           rising-edge clock
//  rst       in   1           synchronous, active-high reset
//  ct        in   8           ciphertext byte
//  ct_valid  in   1           ct is present this cycle
//  ct_ready  out  1           block accepts ct this cycle
//  resync    in   1           reload keystream to KEY_SEED, flush output
//  pt        out  8           recovered plaintext byte
//  pt_valid  out  1           pt holds a byte
//  pt_ready  in   1           sink takes pt this cycle
//  key_dbg   out  8           keystream byte that the next accepted ct uses
//  byte_cnt  out  BYTE_CNT_W  number of bytes accepted since reset/resync
// BEHAVIOUR
//  Reset: key=KEY_SEED, pt=8'h00, pt_valid=0, byte_cnt=0, ct_ready=1 next cycle.
//  Keystream: 8-bit Fibonacci LFSR, fb = k[7]^k[5]^k[4]^k[3]; next = {k[6:0],fb}.
//   Key sequence from A5: A5, 4A, 95, ...
//   Advances exactly once per accepted byte, never on idle/stall cycles.
//  Accept: ct_valid && ct_ready. ct_ready = !pt_valid || pt_ready (comb).
//  Output states: EMPTY (pt_valid=0), FULL (pt_valid=1).
//   EMPTY + accept       -> FULL, pt <= ct^key; latency 1 clk from accept.
//   FULL + pt_ready only -> EMPTY.
//   FULL + pt_ready + accept -> FULL, pt reloaded; full throughput 1 byte/clk.
//   FULL + !pt_ready     -> FULL, pt stable, ct_ready=0, key frozen.
//  byte_cnt: +1 per accept; wraps 2^BYTE_CNT_W-1 -> 0 silently.
//  resync (sync, 1 clk): key<=KEY_SEED, byte_cnt<=0, pt_valid<=0, pt<=0.
//   resync wins over a same-cycle accept: ct_ready=0 while resync=1, byte not taken.
//  rst mid-stream: identical to resync; any held pt is discarded.
//  ct_valid must not drop or change ct until accepted (standard valid/ready).
// CONFIGURATION
//  VERNAM_DECIPH_ASCII_CHK_EN defined: extra port
//   pt_bad out 1: registered with pt, 1 when pt outside 8'h20..8'h7E; cleared
//   by rst/resync; does not block data flow.
//  Undefined: no pt_bad port, no check logic.
// TESTING
//  1 rst, then ct=CD valid, pt_ready=1 -> next clk pt=8'h68('h'), pt_valid=1, byte_cnt=1.
//  2 stream CD,2F back-to-back -> pt 68,65 ('h','e') on consecutive clks; key_dbg A5,4A,95.
//  3 pt_ready=0 with FULL -> ct_ready=0, pt/key_dbg/byte_cnt held 5 clks; release -> resumes in order.
//  4 resync asserted together with ct_valid -> byte not taken, pt_valid=0, key_dbg=A5, byte_cnt=0.
//  5 BYTE_CNT_W=4, 17 accepted bytes -> byte_cnt=1 after wrap; plaintext still correct.
//  6 ASCII_CHK_EN: ct=A5 (pt=00) -> pt_bad=1; ct=CD (pt=68) -> pt_bad=0.

Source files
------------

// File: rtl/vernam_deciph_if.sv
// Valid/ready bundle for the Vernam decipher: ciphertext in, plaintext out.
// The slave modport is the decipher; the master modport is link plus sink.
interface vernam_deciph_if;
  logic [7:0] ct;
  logic       ct_valid;
  logic       ct_ready;
  logic [7:0] pt;
  logic       pt_valid;
  logic       pt_ready;

  modport slave  (input  ct, ct_valid, pt_ready, output ct_ready, pt, pt_valid);
  modport master (output ct, ct_valid, pt_ready, input  ct_ready, pt, pt_valid);
endinterface

// File: rtl/vernam_deciph.sv
// Receive-side Vernam stream decipher: pt = ct ^ LFSR keystream, one-entry output register.
// Define VERNAM_DECIPH_ASCII_CHK_EN to add the pt_bad printable-ASCII flag output.
module vernam_deciph #(
  parameter logic [7:0]  KEY_SEED   = 8'hA5,
  parameter int unsigned BYTE_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  vernam_deciph_if.slave        bus,
  input  logic                  resync,
  output logic [7:0]            key_dbg,
  output logic [BYTE_CNT_W-1:0] byte_cnt
`ifdef VERNAM_DECIPH_ASCII_CHK_EN
  ,
  output logic                  pt_bad
`endif
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e                state_q, state_d;
  logic [7:0]            key_q, key_d;
  logic [7:0]            pt_q, pt_d;
  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
  logic                  accept;

  function automatic logic [7:0] lfsr_step(input logic [7:0] k);
    return {k[6:0], k[7] ^ k[5] ^ k[4] ^ k[3]};
  endfunction

  // Resync (and reset) outrank a pending byte: it is refused, not silently dropped.
  assign bus.ct_ready = !rst && !resync && ((state_q == EMPTY) || bus.pt_ready);
  assign accept       = bus.ct_valid && bus.ct_ready;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    pt_d    = pt_q;
    cnt_d   = cnt_q;
    if (resync) begin
      state_d = EMPTY;
      key_d   = KEY_SEED;
      pt_d    = 8'h00;
      cnt_d   = '0;
    end else begin
      case (state_q)
        EMPTY: if (accept) state_d = FULL;
        FULL:  if (bus.pt_ready && !accept) state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
      if (accept) begin
        pt_d  = bus.ct ^ key_q;
        key_d = lfsr_step(key_q);
        cnt_d = cnt_q + BYTE_CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      key_q   <= KEY_SEED;
      pt_q    <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pt_valid = (state_q == FULL);
  assign bus.pt       = pt_q;
  assign key_dbg      = key_q;
  assign byte_cnt     = cnt_q;

`ifdef VERNAM_DECIPH_ASCII_CHK_EN
  logic bad_q, bad_d;

  // The flag travels with pt, so it is evaluated on the byte being loaded.
  always_comb begin
    bad_d = bad_q;
    if (resync)      bad_d = 1'b0;
    else if (accept) bad_d = (pt_d < 8'h20) || (pt_d > 8'h7E);
  end

  always_ff @(posedge clk) begin
    if (rst) bad_q <= 1'b0;
    else     bad_q <= bad_d;
  end

  assign pt_bad = bad_q;
`endif

endmodule

// File: tb/tb_vernam_deciph.sv
// Scoreboard bench for vernam_deciph: driver pushes expected plaintext, monitor pops on output.
// A second instance with a 4-bit byte counter shares the stimulus to exercise counter wrap.
module tb_vernam_deciph;
  localparam int KS_N = 1024;

  logic clk = 1'b0;
  logic rst;
  logic resync;
  always #5 clk = ~clk;

  vernam_deciph_if bus ();
  vernam_deciph_if bus4 ();

  logic [7:0]  key_dbg, key_dbg4;
  logic [15:0] byte_cnt;
  logic [3:0]  byte_cnt4;
`ifdef VERNAM_DECIPH_ASCII_CHK_EN
  logic pt_bad, pt_bad4;
`endif

  vernam_deciph #(.KEY_SEED(8'hA5), .BYTE_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .resync(resync),
    .key_dbg(key_dbg), .byte_cnt(byte_cnt)
`ifdef VERNAM_DECIPH_ASCII_CHK_EN
    , .pt_bad(pt_bad)
`endif
  );

  vernam_deciph #(.KEY_SEED(8'hA5), .BYTE_CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .resync(resync),
    .key_dbg(key_dbg4), .byte_cnt(byte_cnt4)
`ifdef VERNAM_DECIPH_ASCII_CHK_EN
    , .pt_bad(pt_bad4)
`endif
  );

  assign bus4.ct       = bus.ct;
  assign bus4.ct_valid = bus.ct_valid;
  assign bus4.pt_ready = bus.pt_ready;

  // Reference model: keystream table indexed by bytes accepted since seed load.
  logic [7:0] ks [KS_N];
  int         n_m;
  logic [7:0] exp_q[$];
  logic [7:0] seen[$];
  int         errs   = 0;
  int         checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; acc reports whether the byte is accepted at the next edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic rdy, input logic rs,
                       output logic acc);
    logic exp_ready;
    @(negedge clk);
    bus.ct_valid = v;
    bus.ct       = d;
    bus.pt_ready = rdy;
    resync       = rs;
    #1;
    exp_ready = !rs && ((exp_q.size() == 0) || rdy);
    check("key_dbg",   32'(key_dbg),      32'(ks[n_m]));
    check("byte_cnt",  32'(byte_cnt),     32'(n_m % 65536));
    check("byte_cnt4", 32'(byte_cnt4),    32'(n_m % 16));
    check("pt_valid",  32'(bus.pt_valid), 32'(exp_q.size() != 0));
    check("ct_ready",  32'(bus.ct_ready), 32'(exp_ready));
    acc = v && exp_ready;
    if (rs) begin
      exp_q.delete();
      n_m = 0;
    end else if (acc) begin
      exp_q.push_back(d ^ ks[n_m]);
      n_m++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    resync       = 1'b0;
    bus.ct_valid = 1'b0;
    bus.pt_ready = 1'b0;
    exp_q.delete();
    n_m = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_pt_valid", 32'(bus.pt_valid), 32'd0);
    check("rst_pt",       32'(bus.pt),       32'd0);
    check("rst_key",      32'(key_dbg),      32'hA5);
    check("rst_cnt",      32'(byte_cnt),     32'd0);
    check("rst_ct_ready", 32'(bus.ct_ready), 32'd1);
  endtask

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && !resync && bus.pt_valid) begin
        if (exp_q.size() == 0) begin
          check("pt_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          check("pt",  32'(bus.pt), 32'(exp_q[0]));
          check("pt4", 32'({bus4.pt_valid, bus4.pt}), 32'({1'b1, exp_q[0]}));
`ifdef VERNAM_DECIPH_ASCII_CHK_EN
          check("pt_bad", 32'(pt_bad), 32'((exp_q[0] < 8'h20) || (exp_q[0] > 8'h7E)));
`endif
          if (bus.pt_ready) begin
            seen.push_back(bus.pt);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic       a;
    logic       pending;
    logic [7:0] pbyte;

    rst          = 1'b1;
    resync       = 1'b0;
    bus.ct       = 8'h00;
    bus.ct_valid = 1'b0;
    bus.pt_ready = 1'b0;
    n_m          = 0;

    ks[0] = 8'hA5;
    for (int i = 1; i < KS_N; i++) ks[i] = {ks[i-1][6:0], ^(ks[i-1] & 8'hB8)};

    do_reset();

    // First bytes of "he...": known plaintext and keystream.
    seen.delete();
    cycle(1'b1, 8'hCD, 1'b1, 1'b0, a);
    cycle(1'b1, 8'h2F, 1'b1, 1'b0, a);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, a);
    check("t2_key95", 32'(key_dbg), 32'h95);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, a);
    check("t2_seen_n", 32'(seen.size()), 32'd2);
    if (seen.size() >= 2) begin
      check("t1_pt_h", 32'(seen[0]), 32'h68);
      check("t2_pt_e", 32'(seen[1]), 32'h65);
    end

    // Back-pressure: output held, input refused, keystream frozen.
    cycle(1'b1, 8'h11, 1'b1, 1'b0, a);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h22, 1'b0, 1'b0, a);
    cycle(1'b1, 8'h22, 1'b1, 1'b0, a);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, a);

    // Resync collides with a valid byte.
    cycle(1'b1, 8'h33, 1'b0, 1'b0, a);
    cycle(1'b1, 8'h44, 1'b1, 1'b1, a);
    check("t4_refused", 32'(a), 32'd0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, a);
    check("t4_key", 32'(key_dbg), 32'hA5);
    check("t4_cnt", 32'(byte_cnt), 32'd0);

    // Counter wrap on the narrow instance.
    for (int i = 0; i < 17; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0, a);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, a);
    check("t5_cnt4_wrap", 32'(byte_cnt4), 32'd1);
    check("t5_cnt16",     32'(byte_cnt),  32'd17);

    // ASCII check corner values from a fresh keystream: 00 is bad, 68 is good.
    cycle(1'b0, 8'h00, 1'b1, 1'b1, a);
    cycle(1'b1, 8'hA5, 1'b1, 1'b0, a);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, a);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, a);
    cycle(1'b1, 8'hCD, 1'b1, 1'b0, a);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, a);

    // Reset mid-stream discards a held byte.
    cycle(1'b1, 8'h55, 1'b0, 1'b0, a);
    cycle(1'b1, 8'h66, 1'b0, 1'b0, a);
    do_reset();

    // Randomized traffic with stalls and occasional resync.
    pending = 1'b0;
    pbyte   = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if (!pending && ($urandom_range(3) != 0)) begin
        pending = 1'b1;
        pbyte   = 8'($urandom);
      end
      cycle(pending, pbyte, ($urandom_range(9) < 7), ($urandom_range(49) == 0), a);
      if (a) pending = 1'b0;
    end

    // Drain within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, a);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, a);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
